exec_sequencer: RTL and testbench
=================================

// Module: exec_sequencer
// PURPOSE
//  Run controller for the EnDMe core. Owns the data-memory port mux between the host (loader/readback) and the core.
//  Sequences a run: holds core in reset while host loads, releases it, detects halt, drains, hands memory back.
//  Sits between top-level pins, instr_fetch reset input, and data_mem address/data/write-enable.
// PARAMETERS
//  CNT_W       16      width of run-cycle counter (saturating)
//  MAX_CYCLES  16'hFFFF watchdog limit in RUN cycles (used only with EXEC_SEQ_TIMEOUT_EN)
// PORTS
//  CLK          in   1      clock; all state updates on rising edge
//  RESET        in   1      synchronous, active-high reset
//  host_start   in   1      pulse: begin a run (honoured in IDLE/DONE only)
//  host_req     in   1      host memory access request (level, held until granted)
//  host_we      in   1      1 = write, 0 = read
//  host_addr    in   8      host memory address
//  host_wdata   in   8      host write data
//  host_gnt     out  1      access accepted this cycle
//  host_rdata   out  8      mem_rdata passthrough
//  core_addr    in   8      core data-memory address (reg_file output)
//  core_wdata   in   8      core write data (accumulator)
//  core_we      in   1      core memwrite control
//  core_halt    in   1      halt instruction decoded this cycle
//  core_reset   out  1      drives instr_fetch reset (PC -> 0)
//  mem_addr     out  8      to data_mem addr
//  mem_wdata    out  8      to data_mem data
//  mem_we       out  1      to data_mem write enable
//  busy         out  1      1 in RST_CORE/RUN/DRAIN
//  done         out  1      1 in DONE
//  timeout      out  1      run ended by watchdog (sticky until next start)
//  cycle_count  out  CNT_W  RUN cycles of last/current run
// BEHAVIOUR
//  States: IDLE, RST_CORE, RUN, DRAIN, DONE. RESET (any state, any cycle) -> IDLE next edge.
//  Reset values: state=IDLE, cycle_count=0, timeout=0; outputs then per IDLE decode.
//  IDLE: core_reset=1; host owns memory. host_start -> RST_CORE.
//  RST_CORE: 1 cycle; core_reset=1; mem_we=0, host_gnt=0; cycle_count<=0, timeout<=0. -> RUN.
//  RUN: core_reset=0; mem_* = core_*; host_gnt=0. cycle_count +1/cycle, saturates at all-ones.
//   core_halt=1 -> DRAIN (core_we in the halt cycle is still honoured).
//  DRAIN: 1 cycle; core_reset=1; mem_we=0; lets last write settle. -> DONE.
//  DONE: core_reset=1; done=1; host owns memory; cycle_count/timeout held. host_start -> RST_CORE.
//  Host grant: host_gnt = host_req & (state==IDLE|DONE), combinational. When granted:
//   mem_addr=host_addr, mem_wdata=host_wdata, mem_we=host_we; write lands this edge;
//   read data valid on host_rdata same cycle (async data_mem read). Not granted: mem_we=0 from host.
//  host_start and host_req same cycle in IDLE/DONE: access granted in that cycle, then transition.
//  host_start in RST_CORE/RUN/DRAIN: ignored. host_req outside IDLE/DONE: stalls, no side effects.
//  core_halt outside RUN: ignored. mem_* outputs are combinational from state register and muxed inputs.
// CONFIGURATION
//  EXEC_SEQ_TIMEOUT_EN defined: in RUN, if cycle_count == MAX_CYCLES-1 and no core_halt,
//   timeout<=1 and -> DRAIN (halt in same cycle takes priority, timeout stays 0).
//  Undefined: no watchdog; timeout tied 0; RUN exits only on core_halt or RESET.
// TESTING
//  RESET=1 one cycle -> state IDLE, core_reset=1, done=0, busy=0, cycle_count=0.
//  IDLE host write addr 8'h10 data 8'hA5, then read 8'h10 -> host_gnt=1 both cycles, host_rdata=8'hA5.
//  host_start; core_halt on 5th RUN cycle with core_we=1 addr 8'h20 -> write lands, DRAIN, DONE, cycle_count=5.
//  host_req held during RUN -> host_gnt=0, mem_we follows core_we only; grant on first DONE cycle.
//  RESET asserted mid-RUN -> IDLE next edge, core_reset=1, mem_we=0, cycle_count=0.
//  EXEC_SEQ_TIMEOUT_EN, MAX_CYCLES=8, no halt -> DONE after 8 RUN cycles, timeout=1, cycle_count=8.

Source files
------------

// File: rtl/exec_sequencer.sv
// exec_sequencer: run controller for the EnDMe core, owning the data-memory port mux between host and core.
// Optional watchdog enabled by defining EXEC_SEQ_TIMEOUT_EN (limit set by MAX_CYCLES).
module exec_sequencer #(
    parameter int CNT_W = 16
`ifdef EXEC_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned MAX_CYCLES = 32'h0000_FFFF
`endif
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             host_start,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [7:0]       host_addr,
    input  logic [7:0]       host_wdata,
    output logic             host_gnt,
    output logic [7:0]       host_rdata,
    input  logic [7:0]       mem_rdata,
    input  logic [7:0]       core_addr,
    input  logic [7:0]       core_wdata,
    input  logic             core_we,
    input  logic             core_halt,
    output logic             core_reset,
    output logic [7:0]       mem_addr,
    output logic [7:0]       mem_wdata,
    output logic             mem_we,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [2:0]       state_dbg
);

    // Encoding is visible on state_dbg: 0 IDLE, 1 RST_CORE, 2 RUN, 3 DRAIN, 4 DONE.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RST_CORE = 3'd1,
        RUN      = 3'd2,
        DRAIN    = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count_next;
    logic             timeout_next;

`ifdef EXEC_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            cycle_count <= '0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_next;
            cycle_count <= count_next;
            timeout     <= timeout_next;
        end
    end

    // Handshake: host_req is a level held (with host_we/addr/wdata stable) until
    // host_gnt; the access completes in the cycle host_gnt is high, and a
    // refused request has no side effects.
    always_comb begin
        state_next   = state;
        count_next   = cycle_count;
        timeout_next = timeout;
        core_reset   = 1'b1;
        host_gnt     = 1'b0;
        mem_addr     = host_addr;
        mem_wdata    = host_wdata;
        mem_we       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state)
            IDLE: begin
                host_gnt = host_req;
                mem_we   = host_req & host_we;
                if (host_start) state_next = RST_CORE;
            end
            RST_CORE: begin
                busy         = 1'b1;
                count_next   = '0;
                timeout_next = 1'b0;
                state_next   = RUN;
            end
            RUN: begin
                busy       = 1'b1;
                core_reset = 1'b0;
                mem_addr   = core_addr;
                mem_wdata  = core_wdata;
                mem_we     = core_we;
                if (cycle_count != {CNT_W{1'b1}}) count_next = cycle_count + CNT_W'(1);
                // A halt in the final watchdog cycle wins, so timeout stays clear.
                if (core_halt) begin
                    state_next = DRAIN;
                end
`ifdef EXEC_SEQ_TIMEOUT_EN
                else if (cycle_count == WD_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = DRAIN;
                end
`endif
            end
            DRAIN: begin
                busy       = 1'b1;
                mem_addr   = core_addr;
                mem_wdata  = core_wdata;
                state_next = DONE;
            end
            DONE: begin
                done     = 1'b1;
                host_gnt = host_req;
                mem_we   = host_req & host_we;
                if (host_start) state_next = RST_CORE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign host_rdata = mem_rdata;
    assign state_dbg  = state;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: cycle-by-cycle vector table, read-data scoreboard, and a held-request sequence.
module tb_exec_sequencer;

    localparam int CNT_W = 4;
    localparam int S_IDLE = 0, S_RST = 1, S_RUN = 2, S_DRAIN = 3, S_DONE = 4;

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic             host_start = 1'b0;
    logic             host_req = 1'b0;
    logic             host_we = 1'b0;
    logic [7:0]       host_addr = '0;
    logic [7:0]       host_wdata = '0;
    logic             host_gnt;
    logic [7:0]       host_rdata;
    logic [7:0]       mem_rdata;
    logic [7:0]       core_addr = '0;
    logic [7:0]       core_wdata = '0;
    logic             core_we = 1'b0;
    logic             core_halt = 1'b0;
    logic             core_reset;
    logic [7:0]       mem_addr;
    logic [7:0]       mem_wdata;
    logic             mem_we;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [2:0]       state_dbg;

    always #5 CLK = ~CLK;

    exec_sequencer #(
        .CNT_W(CNT_W)
`ifdef EXEC_SEQ_TIMEOUT_EN
        ,
        .MAX_CYCLES(8)
`endif
    ) dut (
        .CLK(CLK), .RESET(RESET), .host_start(host_start), .host_req(host_req),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .mem_rdata(mem_rdata),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we),
        .core_halt(core_halt), .core_reset(core_reset), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .busy(busy), .done(done),
        .timeout(timeout), .cycle_count(cycle_count), .state_dbg(state_dbg)
    );

    // Data memory with asynchronous read, as data_mem behaves.
    logic [7:0] mem [256];
    assign mem_rdata = mem[mem_addr];
    always @(posedge CLK) if (mem_we) mem[mem_addr] <= mem_wdata;

    typedef struct {
        logic             rst, start, req, we;
        logic [7:0]       ha, hd, ca, cd;
        logic             cwe, halt;
        logic [2:0]       e_st;
        logic             e_gnt, e_we, e_to;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    logic [7:0] shadow [256];
    int         n_cmp = 0;
    int         n_err = 0;
    int         last_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void add(input int rst, input int start, input int req, input int we,
                                input int ha, input int hd, input int ca, input int cd,
                                input int cwe, input int halt, input int e_st, input int e_gnt,
                                input int e_we, input int e_cnt, input int e_to);
        vec_t v;
        v.rst = rst[0]; v.start = start[0]; v.req = req[0]; v.we = we[0];
        v.ha = ha[7:0]; v.hd = hd[7:0]; v.ca = ca[7:0]; v.cd = cd[7:0];
        v.cwe = cwe[0]; v.halt = halt[0]; v.e_st = e_st[2:0]; v.e_gnt = e_gnt[0];
        v.e_we = e_we[0]; v.e_cnt = e_cnt[CNT_W-1:0]; v.e_to = e_to[0];
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int gnt_k;
        vec_t v;

        // rst st go rq we  ha     hd     ca     cd   cwe hlt | state   gnt we cnt to
        add(0, 0, 1, 1, 'h10, 'hA5, 0,     0,     0, 0,  S_IDLE,  1, 1, 0, 0);
        add(0, 0, 1, 0, 'h10, 0,    0,     0,     0, 0,  S_IDLE,  1, 0, 0, 0);
        add(0, 1, 0, 0, 0,    0,    0,     0,     0, 0,  S_IDLE,  0, 0, 0, 0);
        add(0, 1, 1, 1, 'h33, 'hFF, 0,     0,     0, 0,  S_RST,   0, 0, 0, 0);
        add(0, 0, 1, 1, 'h33, 'hFF, 'h21,  'h11,  1, 0,  S_RUN,   0, 1, 0, 0);
        add(0, 1, 1, 0, 'h21, 0,    'h22,  0,     0, 0,  S_RUN,   0, 0, 1, 0);
        add(0, 0, 0, 0, 0,    0,    0,     0,     0, 0,  S_RUN,   0, 0, 2, 0);
        add(0, 0, 1, 0, 'h10, 0,    0,     0,     0, 0,  S_RUN,   0, 0, 3, 0);
        add(0, 0, 0, 0, 0,    0,    'h20,  'h5A,  1, 1,  S_RUN,   0, 1, 4, 0);
        add(0, 0, 0, 0, 0,    0,    'h24,  'h77,  1, 1,  S_DRAIN, 0, 0, 5, 0);
        add(0, 0, 1, 0, 'h20, 0,    0,     0,     0, 0,  S_DONE,  1, 0, 5, 0);
        add(0, 0, 1, 0, 'h21, 0,    0,     0,     0, 0,  S_DONE,  1, 0, 5, 0);
        add(0, 1, 1, 1, 'h40, 'hC3, 0,     0,     0, 0,  S_DONE,  1, 1, 5, 0);
        add(0, 0, 0, 0, 0,    0,    0,     0,     0, 0,  S_RST,   0, 0, 5, 0);
`ifdef EXEC_SEQ_TIMEOUT_EN
        for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_RUN, 0, 0, i, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_DRAIN, 0, 0, 8, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, S_DONE,  0, 0, 8, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_RST,   0, 0, 8, 1);
        for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, (i == 7) ? 1 : 0, S_RUN, 0, 0, i, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_DRAIN, 0, 0, 8, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_DONE,  0, 0, 8, 0);
        last_cnt = 8;
`else
        for (int i = 0; i < 20; i++)
            add(0, 0, 0, 0, 0, 0, 0, 0, 0, (i == 19) ? 1 : 0, S_RUN, 0, 0, (i > 15) ? 15 : i, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_DRAIN, 0, 0, 15, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_DONE,  0, 0, 15, 0);
        last_cnt = 15;
`endif
        add(0, 1, 0, 0, 0,    0, 0,    0,    0, 0, S_DONE, 0, 0, last_cnt, 0);
        add(0, 0, 0, 0, 0,    0, 0,    0,    0, 0, S_RST,  0, 0, last_cnt, 0);
        add(0, 0, 0, 0, 0,    0, 0,    0,    0, 0, S_RUN,  0, 0, 0, 0);
        add(1, 0, 0, 0, 0,    0, 'h50, 'h66, 1, 0, S_RUN,  0, 1, 1, 0);
        add(0, 0, 0, 0, 0,    0, 'h50, 'h67, 1, 0, S_IDLE, 0, 0, 0, 0);
        add(0, 0, 1, 0, 'h40, 0, 0,    0,    0, 0, S_IDLE, 1, 0, 0, 0);
        add(0, 0, 1, 0, 'h50, 0, 0,    0,    0, 0, S_IDLE, 1, 0, 0, 0);
        add(0, 0, 1, 0, 'h10, 0, 0,    0,    0, 0, S_IDLE, 1, 0, 0, 0);

        // One-cycle reset from an unknown state.
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cycle_count", 32'(cycle_count), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        @(posedge CLK); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            RESET = v.rst; host_start = v.start; host_req = v.req; host_we = v.we;
            host_addr = v.ha; host_wdata = v.hd; core_addr = v.ca; core_wdata = v.cd;
            core_we = v.cwe; core_halt = v.halt;
            if (v.req && !v.we && v.e_gnt) exp_q.push_back(shadow[v.ha]);
            @(negedge CLK);
            check($sformatf("v%0d_state", i), 32'(state_dbg), 32'(v.e_st));
            check($sformatf("v%0d_gnt", i), 32'(host_gnt), 32'(v.e_gnt));
            check($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(v.e_we));
            check($sformatf("v%0d_core_reset", i), 32'(core_reset), 32'(v.e_st != 3'(S_RUN)));
            check($sformatf("v%0d_busy", i), 32'(busy),
                  32'(v.e_st == 3'(S_RST) || v.e_st == 3'(S_RUN) || v.e_st == 3'(S_DRAIN)));
            check($sformatf("v%0d_done", i), 32'(done), 32'(v.e_st == 3'(S_DONE)));
            check($sformatf("v%0d_cycle_count", i), 32'(cycle_count), 32'(v.e_cnt));
            check($sformatf("v%0d_timeout", i), 32'(timeout), 32'(v.e_to));
            if (v.e_we) begin
                check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(v.e_gnt ? v.ha : v.ca));
                check($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(v.e_gnt ? v.hd : v.cd));
                if (v.e_gnt) shadow[v.ha] = v.hd;
                else shadow[v.ca] = v.cd;
            end
            if (host_gnt && !host_we) begin
                if (exp_q.size() > 0) check($sformatf("v%0d_rdata", i), 32'(host_rdata), 32'(exp_q.pop_front()));
                else check($sformatf("v%0d_unexpected_read", i), 32'(host_gnt), 32'd0);
            end
            check($sformatf("v%0d_read_pending", i), exp_q.size(), 32'd0);
            exp_q.delete();
            @(posedge CLK); #1;
        end

        // A host write held through a whole run is granted only on the first DONE cycle.
        RESET = 1'b0; host_req = 1'b0; host_we = 1'b0; core_we = 1'b0; core_halt = 1'b0;
        host_start = 1'b1;
        @(posedge CLK); #1;
        host_start = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h77; host_wdata = 8'hEE;
        core_addr = 8'h78; core_wdata = 8'h99;
        gnt_k = -1;
        for (int k = 0; k < 30; k++) begin
            core_halt = (k == 3);
            core_we = (k == 2);
            @(negedge CLK);
            if (host_gnt) begin
                gnt_k = k;
                break;
            end
            check($sformatf("held_k%0d_mem_we", k), 32'(mem_we), 32'(k == 2));
            @(posedge CLK); #1;
        end
        check("held_gnt_cycle", gnt_k, 32'd5);
        check("held_gnt_done", 32'(done), 32'd1);
        check("held_gnt_mem_addr", 32'(mem_addr), 32'h77);
        check("held_gnt_mem_we", 32'(mem_we), 32'd1);
        check("held_cycle_count", 32'(cycle_count), 32'd3);
        @(posedge CLK); #1;
        host_we = 1'b0; core_we = 1'b0; core_halt = 1'b0;
        @(negedge CLK);
        check("held_readback_77", 32'(host_rdata), 32'hEE);
        @(posedge CLK); #1;
        host_addr = 8'h78;
        @(negedge CLK);
        check("held_readback_78", 32'(host_rdata), 32'h99);
        @(posedge CLK); #1;
        host_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
